// File: rtl/serial_parallelizer_pkg.sv
// Shared types and constants for the serial-to-parallel word assembler.
package serial_parallelizer_pkg;

    // IDLE waits for a start bit (framed mode only); SHIFT collects data bits.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sp_state_t;

    localparam int SP_DEFAULT_WIDTH = 16;

    // Width of the bit counter; never narrower than one bit.
    function automatic int sp_count_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sp_bit_counter.sv
// Counts data bits of the word being assembled and flags the bit that completes it.
// i_Clear restarts the count in the same cycle, so a coincident increment
// counts as the first bit of the new word.
module sp_bit_counter #(
    parameter int WIDTH = 16,
    parameter int CW    = 4
) (
    input  logic          i_CLK,
    input  logic          i_RESET,
    input  logic          i_Clear,
    input  logic          i_Inc,
    output logic [CW-1:0] o_Count,
    output logic          o_Wrap
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_base;
    logic          w_wrap;

    // Effective starting count for this cycle and last-bit detection.
    always_comb begin
        w_base = {CW{1'b0}};
        if (i_Clear) begin
            w_base = {CW{1'b0}};
        end else begin
            w_base = r_count;
        end
        w_wrap = i_Inc && (w_base == LAST);
    end

    // Count register: wraps to zero on the completing bit.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_count <= {CW{1'b0}};
        end else if (w_wrap) begin
            r_count <= {CW{1'b0}};
        end else if (i_Inc) begin
            r_count <= w_base + CW'(1);
        end else begin
            r_count <= w_base;
        end
    end

    assign o_Count = r_count;
    assign o_Wrap  = w_wrap;

endmodule

// File: rtl/serial_parallelizer.sv
// Serial-to-parallel converter with optional start-bit framing, a one-word
// output holding register with ready/valid handshake, and a sticky overrun flag.
module serial_parallelizer
    import serial_parallelizer_pkg::*;
#(
    parameter int WIDTH     = SP_DEFAULT_WIDTH,
    parameter int LSB_FIRST = 0,
    parameter int FRAMED    = 0
) (
    input  logic                              i_CLK,
    input  logic                              i_RESET,
    input  logic                              i_Data,
    input  logic                              i_BitEn,
    input  logic                              i_Sync,
    input  logic                              i_Ready,
    output logic [WIDTH-1:0]                  o_Data,
    output logic                              o_Valid,
    output logic                              o_Latch,
    output logic                              o_Overrun,
    output logic [sp_count_bits(WIDTH)-1:0]   o_BitCount
);

    localparam int        CW         = sp_count_bits(WIDTH);
    localparam bit        IS_FRAMED  = (FRAMED != 0);
    localparam bit        IS_LSB     = (LSB_FIRST != 0);
    // State entered on reset and on a realign request.
    localparam sp_state_t ST_REALIGN = IS_FRAMED ? ST_IDLE : ST_SHIFT;

    sp_state_t        r_state;
    sp_state_t        w_state_next;
    sp_state_t        w_eff_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_base;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_latch;
    logic             r_overrun;
    logic             w_shift_bit;
    logic             w_word;
    logic             w_load;
    logic             w_drop;
    logic [CW-1:0]    w_count;

    // A realign request takes effect before this cycle's bit is considered.
    always_comb begin
        w_eff_state  = r_state;
        w_shift_base = r_shift;
        if (i_Sync) begin
            w_eff_state  = ST_REALIGN;
            w_shift_base = {WIDTH{1'b0}};
        end else begin
            w_eff_state  = r_state;
            w_shift_base = r_shift;
        end
        w_shift_bit  = i_BitEn && (w_eff_state == ST_SHIFT);
        w_shift_next = IS_LSB ? {i_Data, w_shift_base[WIDTH-1:1]}
                              : {w_shift_base[WIDTH-2:0], i_Data};
        w_load       = w_word && (!r_valid || i_Ready);
        w_drop       = w_word && r_valid && !i_Ready;
    end

    sp_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .i_CLK   (i_CLK),
        .i_RESET (i_RESET),
        .i_Clear (i_Sync),
        .i_Inc   (w_shift_bit),
        .o_Count (w_count),
        .o_Wrap  (w_word)
    );

    // Next-state logic: start bit opens a frame, completing bit closes it.
    always_comb begin
        w_state_next = w_eff_state;
        case (w_eff_state)
            ST_IDLE: begin
                if (i_BitEn && i_Data) begin
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_word && IS_FRAMED) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            default: begin
                w_state_next = ST_REALIGN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_state <= ST_REALIGN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shift register: takes qualified data bits, cleared on realign.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_shift <= {WIDTH{1'b0}};
        end else if (w_shift_bit) begin
            r_shift <= w_shift_next;
        end else begin
            r_shift <= w_shift_base;
        end
    end

    // Output holding register with handshake, load strobe and sticky overrun.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_data    <= {WIDTH{1'b0}};
            r_valid   <= 1'b0;
            r_latch   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_latch <= w_load;
            if (w_load) begin
                r_data  <= w_shift_next;
                r_valid <= 1'b1;
            end else if (r_valid && i_Ready) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign o_Data     = r_data;
    assign o_Valid    = r_valid;
    assign o_Latch    = r_latch;
    assign o_Overrun  = r_overrun;
    assign o_BitCount = w_count;

endmodule

// File: doc/serial_parallelizer.md
SERIAL_PARALLELIZER -- requirements
Module: serial_parallelizer

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 16, as the parallel word width in bits (legal range 2..64).
REQ-002 The block SHALL expose parameter LSB_FIRST, default 0: 0 places the first received bit in o_Data[WIDTH-1], 1 places it in o_Data[0].
REQ-003 The block SHALL expose parameter FRAMED, default 0: 0 means free-running word boundaries, 1 means each word is preceded by a start bit equal to 1.
REQ-004 The block SHALL have port i_CLK, input, 1 bit, the single clock; all logic samples on its rising edge.
REQ-005 The block SHALL have port i_RESET, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port i_Data, input, 1 bit, the serial data bit.
REQ-007 The block SHALL have port i_BitEn, input, 1 bit, which qualifies i_Data as a valid bit in the current cycle.
REQ-008 The block SHALL have port i_Sync, input, 1 bit, a frame realign request.
REQ-009 The block SHALL have port i_Ready, input, 1 bit, the consumer's accept signal.
REQ-010 The block SHALL have port o_Data, output, WIDTH bits, the assembled word.
REQ-011 The block SHALL have port o_Valid, output, 1 bit, which indicates that o_Data holds an unconsumed word.
REQ-012 The block SHALL have port o_Latch, output, 1 bit, a one-cycle pulse that accompanies each load of o_Data.
REQ-013 The block SHALL have port o_Overrun, output, 1 bit, a sticky flag that marks a dropped word.
REQ-014 The block SHALL have port o_BitCount, output, clog2(WIDTH) bits, the number of bits of the current partial word.

Function
REQ-015 The state machine SHALL have two states: IDLE (FRAMED=1 only, waiting for the start bit) and SHIFT; with FRAMED=0 the block SHALL stay in SHIFT.
REQ-016 In IDLE, a cycle with i_BitEn=1 and i_Data=1 SHALL move the block to SHIFT with count 0; the start bit SHALL NOT be stored, and i_Data=0 SHALL keep the block in IDLE.
REQ-017 In SHIFT, each i_BitEn=1 cycle SHALL shift i_Data into the internal shift register in the direction set by LSB_FIRST and increment the count; cycles with i_BitEn=0 SHALL hold all state.
REQ-018 The bit taken while count==WIDTH-1 SHALL complete the word; the count SHALL wrap to 0, and with FRAMED=1 the state SHALL return to IDLE.
REQ-019 On word completion, if o_Valid==0 or i_Ready==1 in that same cycle, the complete word SHALL appear on o_Data with o_Valid=1 and o_Latch=1 after that clock edge, a latency of one edge from the last bit.
REQ-020 On word completion with o_Valid==1 and i_Ready==0, the word SHALL be discarded, o_Data and o_Valid SHALL be unchanged, and o_Overrun SHALL be set.
REQ-021 o_Valid SHALL clear after an edge at which o_Valid==1 and i_Ready==1, unless a new word loads at the same edge, in which case o_Valid SHALL stay 1.
REQ-022 o_Data SHALL remain stable while o_Valid==1 and the word is not consumed.
REQ-023 o_Latch SHALL be high for exactly one cycle per loaded word and SHALL never be high for a dropped word.
REQ-024 i_Sync=1 SHALL discard the partial word, zero the count, and enter IDLE (FRAMED=1) or SHIFT at count 0 (FRAMED=0); o_Data, o_Valid and o_Overrun SHALL be unaffected.
REQ-025 If i_Sync and i_BitEn are both high in the same cycle, that bit SHALL be treated as the first event after realignment: bit 0 of the new word (FRAMED=0) or the start-bit candidate (FRAMED=1).
REQ-026 Once set, o_Overrun SHALL remain 1 until reset.

Reset
REQ-027 i_RESET=1 at a rising edge SHALL set o_Data=0, o_Valid=0, o_Latch=0, o_Overrun=0, o_BitCount=0 and clear the shift register.
REQ-028 During reset the state SHALL be IDLE (FRAMED=1) or SHIFT (FRAMED=0).
REQ-029 Reset SHALL take priority over i_Sync, i_BitEn and i_Ready, and a reset applied mid-word SHALL discard the partial word.

Structure
REQ-030 Package serial_parallelizer_pkg SHALL hold the state enumeration and the default WIDTH constant.
REQ-031 The bit counter with wrap detection SHALL be a sub-module named sp_bit_counter; everything else SHALL be in serial_parallelizer.

Verification
REQ-032 Scenario 1: WIDTH=16, MSB-first, FRAMED=0, i_BitEn=1, i_Ready=1; bits 1000011001001000 -> o_Data=0x8648, o_Valid=1 and a single o_Latch pulse one edge after the 16th bit.
REQ-033 Scenario 2: same bits with LSB_FIRST=1 -> o_Data=0x1261.
REQ-034 Scenario 3: i_Ready=0; two back-to-back words 0x8648 then 0xFFFF -> o_Data stays 0x8648, o_Overrun=1, and no second o_Latch pulse.
REQ-035 Scenario 4: FRAMED=1; idle zeros, start bit 1, then 0x8648 -> word accepted and state back in IDLE; zeros without a start bit -> no load.
REQ-036 Scenario 5: i_Sync after 7 bits, then a full 16-bit word 0x00A5 -> o_Data=0x00A5 with the partial bits discarded; i_Sync coincident with i_BitEn counts that bit as bit 0.
REQ-037 Scenario 6: i_RESET asserted after 9 bits with o_Valid=1 and o_Overrun=1 -> all outputs 0 after the edge, and the next 16 bits form a clean word.
